// File: rtl/huxi_duty_gen.sv
// huxi_duty_gen: breathing-LED duty generator.
// Ramps a PWM duty up to PWM_CNT and back down to 0 for one channel at a
// time, rotating through CH_NUM channels. Each new (ch, duty) pair is offered
// downstream on a valid/ready handshake once per PWM period; a registered
// reference PWM on led lets the block run without the downstream stage.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | disabled or just reset; counters and outputs cleared
// ST_UP   | duty rising by DUTY_STEP per step, saturating at PWM_CNT
// ST_DOWN | duty falling by DUTY_STEP per step, clamped at 0
module huxi_duty_gen #(
  parameter int PWM_CNT   = 1000,
  parameter int DUTY_STEP = 1,
  parameter int DUTY_W    = 10,
  parameter int CH_NUM    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              duty_rdy,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        ch,
  output logic              duty_vld,
  output logic [CH_NUM-1:0] led
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_CNT - 1);
  localparam logic [DUTY_W:0]   MAX_X    = (DUTY_W+1)'(PWM_CNT);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W+1)'(DUTY_STEP);
  localparam logic [1:0]        CH_LAST  = 2'(CH_NUM - 1);

  logic [1:0]        state;
  logic [DUTY_W-1:0] cnt;
  logic [1:0]        ptr;
  logic              pending;
  logic              step;
  logic [DUTY_W:0]   duty_x;
  logic [DUTY_W:0]   sum_x;
  logic [DUTY_W:0]   next_x;

  assign duty_x = {1'b0, duty};

  // Step decision and next duty; one spare bit keeps saturation from wrapping,
  // and the down path clamps by compare rather than relying on a borrow.
  always_comb begin
    pending = duty_vld && !duty_rdy;
    step    = (state != ST_IDLE) && (cnt == CNT_LAST) && !pending;
    sum_x   = duty_x + STEP_X;
    next_x  = '0;
    if (state == ST_UP) begin
      next_x = (sum_x >= MAX_X) ? MAX_X : sum_x;
    end else if (state == ST_DOWN) begin
      next_x = (duty_x < STEP_X) ? '0 : (duty_x - STEP_X);
    end
  end

  // Period counter, ramp FSM, channel rotation and the duty handshake.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      duty     <= '0;
      ch       <= '0;
      duty_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_UP;
        end
        ST_UP, ST_DOWN: begin
          // cnt parks at the last count while the previous pair is unaccepted
          if (cnt == CNT_LAST) begin
            if (step) cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (step) begin
            duty     <= next_x[DUTY_W-1:0];
            ch       <= ptr;
            duty_vld <= 1'b1;
            if (state == ST_UP && next_x == MAX_X) begin
              state <= ST_DOWN;
            end
            // the zero pair still carries the old channel; rotate afterwards
            if (state == ST_DOWN && next_x == '0) begin
              state <= ST_UP;
              ptr   <= (ptr == CH_LAST) ? 2'd0 : ptr + 2'd1;
            end
          end else if (duty_rdy) begin
            duty_vld <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Reference PWM: only the active channel lights, for the first duty counts.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      led <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        led[i] <= (state != ST_IDLE) && (ch == 2'(i)) && (cnt < duty);
      end
    end
  end

endmodule
